// File: rtl/mux_8a1_pkg.sv
// Shared constants for the registered 8:1 multiplexer.
// The select is three bits wide, one bit per tree level.
package mux_8a1_pkg;

    localparam int SEL_W = 3;

endpackage : mux_8a1_pkg

// File: rtl/mux_8a1_mux2a1.sv
// Combinational 2:1 selector used as the building block of the 8:1 tree.
// Pure logic; no state.
module mux2a1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule : mux2a1

// File: rtl/mux_8a1.sv
// Registered 8:1 multiplexer: a three-level tree of 2:1 selectors feeds one output register.
// {S0,S1,S2} forms the select index with S0 as the most significant bit.
module mux_8a1
    import mux_8a1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D000,
    input  logic [WIDTH-1:0] D001,
    input  logic [WIDTH-1:0] D010,
    input  logic [WIDTH-1:0] D011,
    input  logic [WIDTH-1:0] D100,
    input  logic [WIDTH-1:0] D101,
    input  logic [WIDTH-1:0] D110,
    input  logic [WIDTH-1:0] D111,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
    output logic [WIDTH-1:0] Y
);

    logic [SEL_W-1:0] w_sel;
    logic [WIDTH-1:0] w_l1_00;
    logic [WIDTH-1:0] w_l1_01;
    logic [WIDTH-1:0] w_l1_10;
    logic [WIDTH-1:0] w_l1_11;
    logic [WIDTH-1:0] w_l2_0;
    logic [WIDTH-1:0] w_l2_1;
    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] r_y;

    assign w_sel = {S0, S1, S2};

    // Level 1 resolves the LSB (S2) between adjacent input pairs.
    mux2a1 #(.WIDTH(WIDTH)) u_l1_00 (.a(D000), .b(D001), .s(w_sel[0]), .y(w_l1_00));
    mux2a1 #(.WIDTH(WIDTH)) u_l1_01 (.a(D010), .b(D011), .s(w_sel[0]), .y(w_l1_01));
    mux2a1 #(.WIDTH(WIDTH)) u_l1_10 (.a(D100), .b(D101), .s(w_sel[0]), .y(w_l1_10));
    mux2a1 #(.WIDTH(WIDTH)) u_l1_11 (.a(D110), .b(D111), .s(w_sel[0]), .y(w_l1_11));

    mux2a1 #(.WIDTH(WIDTH)) u_l2_0  (.a(w_l1_00), .b(w_l1_01), .s(w_sel[1]), .y(w_l2_0));
    mux2a1 #(.WIDTH(WIDTH)) u_l2_1  (.a(w_l1_10), .b(w_l1_11), .s(w_sel[1]), .y(w_l2_1));

    mux2a1 #(.WIDTH(WIDTH)) u_l3    (.a(w_l2_0), .b(w_l2_1), .s(w_sel[2]), .y(w_mux));

    // Output register: reloads every cycle, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= {WIDTH{1'b0}};
        end else begin
            r_y <= w_mux;
        end
    end

    assign Y = r_y;

endmodule : mux_8a1

// File: tb/tb_mux_8a1.sv
// Scoreboard bench for mux_8a1: WIDTH=1 and WIDTH=8 instances driven with the same select.
// Expected values come from an array-indexed model and are checked by a separate monitor.
module tb_mux_8a1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s0, s1, s2;
    logic [0:0] d1 [8];
    logic [7:0] d8 [8];
    logic [0:0] y1;
    logic [7:0] y8;

    logic [0:0] q1 [$];
    logic [7:0] q8 [$];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mux_8a1 #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .D000(d1[0]), .D001(d1[1]), .D010(d1[2]), .D011(d1[3]),
        .D100(d1[4]), .D101(d1[5]), .D110(d1[6]), .D111(d1[7]),
        .S0(s0), .S1(s1), .S2(s2), .Y(y1)
    );

    mux_8a1 #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n),
        .D000(d8[0]), .D001(d8[1]), .D010(d8[2]), .D011(d8[3]),
        .D100(d8[4]), .D101(d8[5]), .D110(d8[6]), .D111(d8[7]),
        .S0(s0), .S1(s1), .S2(s2), .Y(y8)
    );

    function automatic int sel_idx();
        return int'(s0) * 4 + int'(s1) * 2 + int'(s2);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic set_sel(input int k);
        s0 = k[2];
        s1 = k[1];
        s2 = k[0];
    endtask

    // Issue one clock of stimulus: record the expected post-edge Y, then wait past the edge.
    task automatic step();
        if (rst_n) begin
            q1.push_back(d1[sel_idx()]);
            q8.push_back(d8[sel_idx()]);
        end else begin
            q1.push_back(1'b0);
            q8.push_back(8'h00);
        end
        @(negedge clk);
    endtask

    // Monitor: after every rising edge compare Y against the oldest pending expectation.
    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) check("y_w1", {7'd0, y1}, {7'd0, q1.pop_front()});
        if (q8.size() > 0) check("y_w8", y8, q8.pop_front());
    end

    initial begin
        logic [7:0] pattern;
        pattern = 8'b1001_0110;  // bit k is Dk for k=0..7: 0,1,1,0,1,0,0,1
        rst_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            d1[k] = pattern[k];
            d8[k] = 8'h10 + 8'(k);
        end
        set_sel(1);
        #1;
        check("reset_w1", {7'd0, y1}, 8'h00);
        check("reset_w8", y8, 8'h00);
        @(negedge clk);

        // Reset held while clocking, then release.
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Full sweep 000..111.
        for (int k = 0; k < 8; k++) begin
            set_sel(k);
            step();
        end

        // Latency: a mid-cycle select change is invisible until the next edge.
        set_sel(0);
        step();
        #2;
        set_sel(1);
        #1;
        check("latency_hold_w1", {7'd0, y1}, 8'h00);
        check("latency_hold_w8", y8, 8'h10);
        step();

        // Asynchronous reset between edges with Y=1.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_w1", {7'd0, y1}, 8'h00);
        check("async_rst_w8", y8, 8'h00);
        @(negedge clk);
        step();
        rst_n = 1'b1;

        // Isolation: only D101 may influence Y when sel=101.
        set_sel(5);
        step();
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 8; k++) begin
                if (k != 5) begin
                    d1[k] = ~d1[k];
                    d8[k] = ~d8[k];
                end
            end
            step();
        end
        d1[5] = 1'b1;
        d8[5] = 8'hA5;
        step();

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 8; k++) begin
                d1[k] = 1'($urandom);
                d8[k] = 8'($urandom);
            end
            set_sel(int'($urandom_range(7, 0)));
            rst_n = ($urandom_range(19, 0) != 0);
            step();
        end
        rst_n = 1'b1;
        @(negedge clk);

        check("queue_drained", 8'(q1.size() + q8.size()), 8'h00);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule : tb_mux_8a1
